// File: rtl/lsu_mem_port.sv
// Load/store front-end for the byte-lane block RAM: one RV32I request at a time, lane steering and load extension.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu_mem_port #(
    parameter int RAM_AW = 12,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_resp_valid,
    output logic [XLEN-1:0]   o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_read_req,
    output logic [RAM_AW-1:0] o_read_addr,
    input  logic [XLEN-1:0]   i_read_data,
    output logic              o_write_enable,
    output logic [3:0]        o_byte_enable,
    output logic [RAM_AW-1:0] o_write_addr,
    output logic [XLEN-1:0]   o_write_data
);

    typedef enum logic [1:0] {IDLE, RD, RDW, RESP} state_t;

    state_t          state;
    logic [2:0]      ld_fn;
    logic [1:0]      ld_lane;

    logic [1:0]      size;
    logic            illegal;
    logic            misal;
    logic            req_err;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;

    // Address bits above the RAM window alias by design.
    logic unused_ok;
    assign unused_ok = ^{i_req_addr[XLEN-1:RAM_AW+2], misal};

    assign o_req_ready = (state == IDLE);

    always_comb begin
        size    = i_req_funct3[1:0];
        illegal = (size == 2'b11) || (i_req_we ? i_req_funct3[2] : (i_req_funct3 == 3'b110));
        misal   = ((size == 2'b01) && i_req_addr[0]) ||
                  ((size == 2'b10) && (i_req_addr[1:0] != 2'b00));
        lane    = i_req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = illegal || misal;
`else
        req_err = illegal;
        if (size == 2'b01)
            lane[0] = 1'b0;
        else if (size == 2'b10)
            lane = 2'b00;
`endif
        case (size)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{i_req_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = i_req_wdata;
            end
        endcase
    end

    // funct3[2] selects zero-extension for LBU/LHU.
    always_comb begin
        ld_byte = i_read_data[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? i_read_data[31:16] : i_read_data[15:0];
        case (ld_fn[1:0])
            2'b00:   ld_fmt = {{24{~ld_fn[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{~ld_fn[2] & ld_half[15]}}, ld_half};
            default: ld_fmt = i_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ld_fn          <= '0;
            ld_lane        <= '0;
            o_resp_valid   <= 1'b0;
            o_resp_rdata   <= '0;
            o_resp_err     <= 1'b0;
            o_read_req     <= 1'b0;
            o_read_addr    <= '0;
            o_write_enable <= 1'b0;
            o_byte_enable  <= '0;
            o_write_addr   <= '0;
            o_write_data   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (i_req_valid) begin
                    o_resp_rdata <= '0;
                    if (req_err) begin
                        o_resp_valid <= 1'b1;
                        o_resp_err   <= 1'b1;
                        state        <= RESP;
                    end else if (i_req_we) begin
                        o_write_enable <= 1'b1;
                        o_byte_enable  <= be;
                        o_write_addr   <= i_req_addr[RAM_AW+1:2];
                        o_write_data   <= wdata_rep;
                        o_resp_valid   <= 1'b1;
                        o_resp_err     <= 1'b0;
                        state          <= RESP;
                    end else begin
                        o_read_req  <= 1'b1;
                        o_read_addr <= i_req_addr[RAM_AW+1:2];
                        ld_fn       <= i_req_funct3;
                        ld_lane     <= lane;
                        state       <= RD;
                    end
                end
                RD: begin
                    o_read_req <= 1'b0;
                    state      <= RDW;
                end
                RDW: begin
                    o_resp_rdata <= ld_fmt;
                    o_resp_err   <= 1'b0;
                    o_resp_valid <= 1'b1;
                    state        <= RESP;
                end
                default: begin
                    o_resp_valid   <= 1'b0;
                    o_resp_rdata   <= '0;
                    o_resp_err     <= 1'b0;
                    o_write_enable <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-addressed reference memory and request-level model, one negedge compare process.
module tb_lsu_mem_port;
    localparam int AW   = 12;
    localparam int MEMB = 4 * (1 << AW);

    logic        clk = 1'b0, rst = 1'b0, clk_en = 1'b0;
    logic        i_req_valid = 1'b0, i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = '0;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0;
    logic        o_req_ready, o_resp_valid, o_resp_err, o_read_req, o_write_enable;
    logic [31:0] o_resp_rdata, o_write_data;
    logic [31:0] i_read_data = '0;
    logic [AW-1:0] o_read_addr, o_write_addr;
    logic [3:0]  o_byte_enable;

    always #5 clk = ~clk;

    lsu_mem_port #(.RAM_AW(AW), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
        .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 29) ^ (i >> 6) ^ 90);
    endfunction

    // Byte-lane RAM with registered read, sharing the clock enable.
    logic [7:0] ram [MEMB];
    logic       ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < MEMB; i++) ram[i] <= pat(i);
        end else if (clk_en) begin
            if (o_write_enable)
                for (int k = 0; k < 4; k++)
                    if (o_byte_enable[k]) ram[{o_write_addr, 2'(k)}] <= o_write_data[8*k +: 8];
            if (o_read_req)
                i_read_data <= {ram[{o_read_addr, 2'd3}], ram[{o_read_addr, 2'd2}],
                                ram[{o_read_addr, 2'd1}], ram[{o_read_addr, 2'd0}]};
        end
    end

    int en_mode = 0;
    always @(posedge clk) begin
        #1;
        case (en_mode)
            0:       clk_en = 1'b1;
            1:       clk_en = ~clk_en;
            default: clk_en = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Literal expectations for directed requests.
    bit          pin_on = 0, pin_we_on = 0, pin_err = 0;
    logic [31:0] pin_rdata = '0, pin_wdata = '0;
    logic [3:0]  pin_be = '0;
    logic [AW-1:0] pin_waddr = '0;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state, owned by the compare process.
    logic [7:0]  ref_mem [MEMB];
    bit          ref_ready = 0, pend = 0, seen = 0;
    bit          exp_err, exp_wr, exp_ld;
    int          edges, rd_edges, exp_lat, exp_rd, acc_cnt = 0;
    int          st_ba, st_nb;
    logic [31:0] st_wdata, exp_rdata, exp_wdata;
    logic [3:0]  exp_be;
    logic [AW-1:0] exp_addr;

    always @(negedge clk) begin : mon
        int nb, ba;
        bit ill, mis;
        logic [31:0] v;
        if (!ref_ready) begin
            for (int i = 0; i < MEMB; i++) ref_mem[i] = pat(i);
            ref_ready = 1;
        end
        if (!rst) begin
            pend = 0;
            chk("rst_ready", o_req_ready, 1);
            chk("rst_resp_valid", o_resp_valid, 0);
            chk("rst_rdata", o_resp_rdata, 0);
            chk("rst_err", o_resp_err, 0);
            chk("rst_read_req", o_read_req, 0);
            chk("rst_read_addr", o_read_addr, 0);
            chk("rst_we", o_write_enable, 0);
            chk("rst_be", o_byte_enable, 0);
            chk("rst_waddr", o_write_addr, 0);
            chk("rst_wdata", o_write_data, 0);
        end else begin
            if (!pend) begin
                chk("idle_ready", o_req_ready, 1);
                chk("idle_resp_valid", o_resp_valid, 0);
                chk("idle_we", o_write_enable, 0);
                chk("idle_read_req", o_read_req, 0);
            end else begin
                chk("busy_ready", o_req_ready, 0);
                if (o_resp_valid) begin
                    chk("resp_rdata", o_resp_rdata, exp_rdata);
                    chk("resp_err", o_resp_err, exp_err);
                    if (!seen) begin
                        seen = 1;
                        chk("latency", edges, exp_lat);
                        chk("read_req_edges", rd_edges, exp_rd);
                        if (pin_on) begin
                            chk("pin_rdata", o_resp_rdata, pin_rdata);
                            chk("pin_err", o_resp_err, pin_err);
                        end
                    end
                end
                chk("we_level", o_write_enable, exp_wr & o_resp_valid);
                if (o_write_enable) begin
                    chk("waddr", o_write_addr, exp_addr);
                    chk("be", o_byte_enable, exp_be);
                    chk("wdata", o_write_data, exp_wdata);
                    if (pin_we_on) begin
                        chk("pin_waddr", o_write_addr, pin_waddr);
                        chk("pin_be", o_byte_enable, pin_be);
                        chk("pin_wdata", o_write_data, pin_wdata);
                    end
                end
                if (o_read_req) begin
                    chk("read_on_load", exp_ld, 1);
                    chk("raddr", o_read_addr, exp_addr);
                end
            end
            if (clk_en) begin
                if (pend) begin
                    edges++;
                    if (o_read_req) rd_edges++;
                    if (o_resp_valid) begin
                        pend = 0;
                        if (exp_wr)
                            for (int i = 0; i < st_nb; i++) ref_mem[st_ba + i] = st_wdata[8*i +: 8];
                    end else if (edges > 12) begin
                        chk("resp_timeout", o_resp_valid, 1);
                        pend = 0;
                    end
                end else if (i_req_valid) begin
                    nb  = 1 << i_req_funct3[1:0];
                    ill = (i_req_funct3[1:0] == 2'b11) ||
                          (i_req_we ? i_req_funct3[2] : (i_req_funct3 == 3'b110));
                    mis = (i_req_addr % nb) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
                    exp_err = ill || mis;
`else
                    exp_err = ill;
`endif
                    ba        = int'(i_req_addr % MEMB) / nb * nb;
                    exp_wr    = i_req_we && !exp_err;
                    exp_ld    = !i_req_we && !exp_err;
                    exp_lat   = exp_ld ? 3 : 1;
                    exp_rd    = exp_ld ? 1 : 0;
                    exp_addr  = AW'(ba / 4);
                    exp_rdata = '0;
                    exp_be    = '0;
                    exp_wdata = '0;
                    if (exp_wr) begin
                        for (int i = 0; i < nb; i++) exp_be[(ba + i) % 4] = 1'b1;
                        for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = i_req_wdata[8*(k % nb) +: 8];
                        st_ba = ba; st_nb = nb; st_wdata = i_req_wdata;
                    end
                    if (exp_ld) begin
                        v = '0;
                        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[ba + i];
                        if (!i_req_funct3[2] && nb < 4 && v[8*nb-1])
                            for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
                        exp_rdata = v;
                    end
                    pend = 1; seen = 0; edges = 1; rd_edges = 0;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int a0;
        @(posedge clk); #1;
        i_req_we = we; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = d;
        i_req_valid = 1'b1;
        a0 = acc_cnt;
        for (int n = 0; n < 200 && acc_cnt == a0; n++) begin @(posedge clk); #1; end
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        for (int n = 0; n < 200 && pend; n++) begin @(posedge clk); #1; end
    endtask

    task automatic ld_pin(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r, input bit e);
        pin_on = 1; pin_rdata = r; pin_err = e;
        issue(1'b0, f3, a, 32'h0);
        pin_on = 0;
    endtask

    task automatic st_pin(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [AW-1:0] wa, input logic [3:0] b, input logic [31:0] wd);
        pin_on = 1; pin_rdata = 0; pin_err = 0;
        pin_we_on = 1; pin_waddr = wa; pin_be = b; pin_wdata = wd;
        issue(1'b1, f3, a, d);
        pin_on = 0; pin_we_on = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [2:0] f3;
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        rst = 1'b1;

        st_pin(3'd2, 32'h0000_0010, 32'hDEADBEEF, 12'd4, 4'b1111, 32'hDEADBEEF);
        st_pin(3'd0, 32'h0000_0013, 32'h0000_00A5, 12'd4, 4'b1000, 32'hA5A5A5A5);
        ld_pin(3'd0, 32'h0000_0013, 32'hFFFFFFA5, 0);
        ld_pin(3'd4, 32'h0000_0013, 32'h000000A5, 0);
        st_pin(3'd2, 32'h0000_0020, 32'h80011234, 12'd8, 4'b1111, 32'h80011234);
        ld_pin(3'd1, 32'h0000_0022, 32'hFFFF8001, 0);
        ld_pin(3'd5, 32'h0000_0022, 32'h00008001, 0);
        st_pin(3'd1, 32'h0000_002A, 32'h0000BEEF, 12'd10, 4'b1100, 32'hBEEFBEEF);
        st_pin(3'd2, 32'h0000_0004, 32'h11223344, 12'd1, 4'b1111, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
        ld_pin(3'd2, 32'h0000_0006, 32'h0, 1);
`else
        ld_pin(3'd2, 32'h0000_0006, 32'h11223344, 0);
`endif
        ld_pin(3'd3, 32'h0000_0020, 32'h0, 1);
        pin_on = 1; pin_rdata = 0; pin_err = 1;
        issue(1'b1, 3'd4, 32'h0000_0020, 32'h12345678);
        pin_on = 0;
        ld_pin(3'd2, 32'hFFFF_C020, 32'h80011234, 0);

        en_mode = 1;
        ld_pin(3'd2, 32'h0000_0020, 32'h80011234, 0);
        en_mode = 0;

        // Reset lands while the store strobe is up; the write must never reach RAM.
        @(posedge clk); #1;
        i_req_we = 1'b1; i_req_funct3 = 3'd2; i_req_addr = 32'h40; i_req_wdata = 32'hFFFFFFFF;
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        issue(1'b0, 3'd2, 32'h0000_0040, 32'h0);

        en_mode = 2;
        for (int t = 0; t < 400; t++) begin
            f3 = 3'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), f3, $urandom & 32'hFFFF_C0FF, $urandom);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
